// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
// Also used by pc_gen_perf, the optional counter block enabled by PC_GEN_PERF_EN.
package pc_gen_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    PCG_BOOT,
    PCG_RUN,
    PCG_REDIR
  } pcgen_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] target;
    logic            misaligned;
  } redirect_t;

  // Instruction addresses must be word aligned; bit 0 is already cleared by the jbu.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_gen_perf.sv
// Free-running redirect and fetch-handshake counters for pc_gen.
// Instantiated only when PC_GEN_PERF_EN is defined; both counters wrap.
module pc_gen_perf
  import pc_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_taken,
  input  logic        fetch_fire,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_fetches
);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_redirects <= '0;
      perf_fetches   <= '0;
    end else begin
      if (redirect_taken) perf_redirects <= perf_redirects + 32'd1;
      if (fetch_fire)     perf_fetches   <= perf_fetches + 32'd1;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator and fetch-redirect stage between the IEU and instruction fetch.
// Optional PC_GEN_PERF_EN adds perf_redirects/perf_fetches counter outputs.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            je,
  input  logic [XLEN-1:0] je_target,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic            flush,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_tval
`ifdef PC_GEN_PERF_EN
  ,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_fetches
`endif
);

  pcgen_state_e    state, state_next;
  logic [XLEN-1:0] pc_q, pc_next;
  logic [XLEN-1:0] tval_q, tval_next;
  logic            trap_q, trap_next;
  logic            fetch_fire;
  redirect_t       redir;

  // EX contents during BOOT and REDIR belong to squashed instructions, so only RUN may redirect.
  always_comb begin
    redir.valid      = ex_valid & je & (state == PCG_RUN);
    redir.target     = je_target;
    redir.misaligned = is_misaligned(je_target);
  end

  assign fetch_valid = (state != PCG_BOOT);
  assign fetch_fire  = fetch_valid & fetch_ready;
  assign flush       = (state == PCG_REDIR);
  assign fetch_pc    = pc_q;
  assign trap_valid  = trap_q;
  assign trap_tval   = tval_q;

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    trap_next  = 1'b0;
    tval_next  = tval_q;
    case (state)
      PCG_BOOT: begin
        state_next = PCG_RUN;
      end
      PCG_RUN: begin
        if (redir.valid) begin
          // A redirect wins over a handshake completing in the same cycle.
          state_next = PCG_REDIR;
          trap_next  = redir.misaligned;
          if (redir.misaligned) begin
            pc_next   = TRAP_VECTOR;
            tval_next = redir.target;
          end else begin
            pc_next = redir.target;
          end
        end else if (fetch_fire) begin
          pc_next = pc_q + PC_STEP;
        end
      end
      PCG_REDIR: begin
        state_next = PCG_RUN;
        if (fetch_fire) pc_next = pc_q + PC_STEP;
      end
      default: begin
        state_next = PCG_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= PCG_BOOT;
      pc_q   <= RESET_VECTOR;
      trap_q <= 1'b0;
      tval_q <= '0;
    end else begin
      state  <= state_next;
      pc_q   <= pc_next;
      trap_q <= trap_next;
      tval_q <= tval_next;
    end
  end

`ifdef PC_GEN_PERF_EN
  pc_gen_perf u_perf (
    .clk            (clk),
    .reset          (reset),
    .redirect_taken (redir.valid),
    .fetch_fire     (fetch_fire),
    .perf_redirects (perf_redirects),
    .perf_fetches   (perf_fetches)
  );
`else
  // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios then randomized traffic vs. a behavioural model.
// Connects and checks the perf counters when PC_GEN_PERF_EN is defined.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        je;
  logic [31:0] je_target;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        trap_valid;
  logic [31:0] trap_tval;
`ifdef PC_GEN_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_fetches;
`endif

  int checks   = 0;
  int failures = 0;

  // Behavioural model of what fetch should see this cycle.
  bit          m_running;
  bit          m_flush;
  bit          m_trap;
  logic [31:0] m_pc;
  logic [31:0] m_tval;
  logic [31:0] m_redirects;
  logic [31:0] m_fetches;

  logic        r_reset, r_ev, r_je, r_rdy;
  logic [31:0] r_tgt;

  pc_gen #(
    .RESET_VECTOR (RESET_VEC),
    .TRAP_VECTOR  (TRAP_VEC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .je          (je),
    .je_target   (je_target),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .flush       (flush),
    .trap_valid  (trap_valid),
    .trap_tval   (trap_tval)
`ifdef PC_GEN_PERF_EN
    ,
    .perf_redirects (perf_redirects),
    .perf_fetches   (perf_fetches)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Redirects are accepted only after boot and never in the cycle that is already flushing.
  task automatic modelStep(input logic r, input logic ev, input logic j, input logic [31:0] tgt,
                           input logic rdy);
    bit take;
    if (r) begin
      m_running = 0; m_flush = 0; m_trap = 0;
      m_pc = RESET_VEC; m_tval = '0;
      m_redirects = '0; m_fetches = '0;
    end else if (!m_running) begin
      m_running = 1; m_flush = 0; m_trap = 0;
    end else begin
      take = ev && j && !m_flush;
      if (rdy) m_fetches = m_fetches + 1;
      if (take) begin
        m_redirects = m_redirects + 1;
        m_flush = 1;
        m_trap  = (tgt % 4) != 0;
        if (m_trap) begin
          m_pc   = TRAP_VEC;
          m_tval = tgt;
        end else begin
          m_pc = tgt;
        end
      end else begin
        m_flush = 0;
        m_trap  = 0;
        if (rdy) m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic checkModel();
    checkOutput("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_running});
    checkOutput("fetch_pc",    fetch_pc,             m_pc);
    checkOutput("flush",       {31'b0, flush},       {31'b0, m_flush});
    checkOutput("trap_valid",  {31'b0, trap_valid},  {31'b0, m_trap});
    if (m_trap) checkOutput("trap_tval", trap_tval, m_tval);
`ifdef PC_GEN_PERF_EN
    checkOutput("perf_redirects", perf_redirects, m_redirects);
    checkOutput("perf_fetches",   perf_fetches,   m_fetches);
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the rising edge,
  // then compare at the next falling edge.
  task automatic applyStimulus(input logic r, input logic ev, input logic j, input logic [31:0] tgt,
                               input logic rdy);
    reset = r; ex_valid = ev; je = j; je_target = tgt; fetch_ready = rdy;
    @(posedge clk);
    modelStep(r, ev, j, tgt, rdy);
    @(negedge clk);
    checkModel();
  endtask

  initial begin
    $display("[TB] starting pc_gen bench");
    reset = 1'b1; ex_valid = 1'b0; je = 1'b0; je_target = '0; fetch_ready = 1'b0;

    applyStimulus(1, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 1);
    checkOutput("rst_pc",    fetch_pc,             RESET_VEC);
    checkOutput("rst_valid", {31'b0, fetch_valid}, 32'h0);
    checkOutput("rst_flush", {31'b0, flush},       32'h0);
    checkOutput("rst_trap",  {31'b0, trap_valid},  32'h0);
    checkOutput("rst_tval",  trap_tval,            32'h0);

    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("first_valid", {31'b0, fetch_valid}, 32'h1);
    checkOutput("first_pc",    fetch_pc,             32'h0);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("seq_4", fetch_pc, 32'h4);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("seq_8", fetch_pc, 32'h8);

    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 32'h0, 0);
      checkOutput("hold_pc",    fetch_pc,             32'h8);
      checkOutput("hold_valid", {31'b0, fetch_valid}, 32'h1);
    end
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("resume_c", fetch_pc, 32'hC);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("seq_10", fetch_pc, 32'h10);

    applyStimulus(0, 1, 1, 32'h200, 1);
    checkOutput("redir_pc",    fetch_pc,        32'h200);
    checkOutput("redir_flush", {31'b0, flush},  32'h1);
    applyStimulus(0, 1, 1, 32'h300, 1);
    checkOutput("b2b_pc",    fetch_pc,       32'h204);
    checkOutput("b2b_flush", {31'b0, flush}, 32'h0);

    applyStimulus(0, 1, 1, 32'h202, 1);
    checkOutput("trap_pulse", {31'b0, trap_valid}, 32'h1);
    checkOutput("trap_tval",  trap_tval,           32'h202);
    checkOutput("trap_pc",    fetch_pc,            TRAP_VEC);
    checkOutput("trap_flush", {31'b0, flush},      32'h1);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("trap_clear", {31'b0, trap_valid}, 32'h0);
    checkOutput("after_trap", fetch_pc,            32'h104);

    applyStimulus(0, 1, 1, 32'h400, 0);
    checkOutput("redir2_pc", fetch_pc, 32'h400);
    applyStimulus(1, 1, 1, 32'h500, 1);
    checkOutput("rst_redir_pc",    fetch_pc,             RESET_VEC);
    checkOutput("rst_redir_valid", {31'b0, fetch_valid}, 32'h0);
    checkOutput("rst_redir_flush", {31'b0, flush},       32'h0);

    applyStimulus(0, 1, 1, 32'h600, 1);
    checkOutput("boot_ignore_pc", fetch_pc,       RESET_VEC);
    checkOutput("boot_no_flush",  {31'b0, flush}, 32'h0);
    applyStimulus(0, 1, 1, 32'hFFFF_FFFC, 1);
    checkOutput("top_pc", fetch_pc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("wrap_pc", fetch_pc, 32'h0);

    for (int i = 0; i < 400; i++) begin
      r_reset = ($urandom_range(0, 63) == 0);
      r_ev    = ($urandom_range(0, 3) != 0);
      r_je    = ($urandom_range(0, 3) == 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_tgt   = $urandom;
      if ($urandom_range(0, 15) == 0) r_tgt = 32'hFFFF_FFF0;
      if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
      else r_tgt[0] = 1'b0;
      applyStimulus(r_reset, r_ev, r_je, r_tgt, r_rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
